// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: FSM states,
// the one-hot op encodings and a small request-validation helper.
package muldiv_ctrl_pkg;

   localparam int MULDIV_XLEN = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      CORR = 2'd2
   } muldiv_state_type;

   // First member is the MSB, so mul_op = 4'b1000 selects mul.
   typedef struct packed {
      logic mul;
      logic mulh;
      logic mulhsu;
      logic mulhu;
   } mul_op_type;

   typedef struct packed {
      logic div;
      logic divu;
      logic rem;
      logic remu;
   } div_op_type;

   // A request is only legal when exactly one of the eight op bits is set.
   function automatic logic isOneHot8(input logic [7:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n += int'(v[i]);
      end
      return (n == 1);
   endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the execute stage and the mul/div
// sequencer. The execute stage is the master; the sequencer is the slave.
interface muldiv_ctrl_if import muldiv_ctrl_pkg::*; #(
   parameter int XLEN = MULDIV_XLEN
) ();

   logic            req_valid;
   logic            req_ready;
   mul_op_type      mul_op;
   div_op_type      div_op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            resp_valid;
   logic [XLEN-1:0] resp_result;

   modport master (
      output req_valid, mul_op, div_op, rs1, rs2,
      input  req_ready, resp_valid, resp_result
   );

   modport slave (
      input  req_valid, mul_op, div_op, rs1, rs2,
      output req_ready, resp_valid, resp_result
   );

endinterface

// File: rtl/muldiv_ctrl_step.sv
// One combinational iteration of either shift-add multiply or restoring
// divide. Both share a single XLEN+1 bit adder with carry-out.
//  Multiply: {hi,lo} holds partial product / remaining multiplier.
//  Divide:   hi holds the partial remainder, lo the dividend/quotient.
module muldiv_step import muldiv_ctrl_pkg::*; #(
   parameter int XLEN = MULDIV_XLEN
) (
   input  logic            isDiv,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] opnd,
   output logic [XLEN-1:0] hiNext,
   output logic [XLEN-1:0] loNext
);

   logic [XLEN:0]   addA;
   logic [XLEN:0]   addB;
   logic            cin;
   logic [XLEN+1:0] sum;

   // Adder operand select: trial subtract for divide, conditional add for multiply.
   always_comb begin
      addA = {1'b0, hi};
      addB = '0;
      cin  = 1'b0;
      if (isDiv) begin
         addA = {hi, lo[XLEN-1]};
         addB = ~{1'b0, opnd};
         cin  = 1'b1;
      end else if (lo[0]) begin
         addB = {1'b0, opnd};
      end
   end

   assign sum = {1'b0, addA} + {1'b0, addB} + {{(XLEN+1){1'b0}}, cin};

   // Carry-out of the trial subtract is the quotient bit; on borrow the shifted remainder is restored.
   always_comb begin
      if (isDiv) begin
         hiNext = sum[XLEN+1] ? sum[XLEN-1:0] : addA[XLEN-1:0];
         loNext = {lo[XLEN-2:0], sum[XLEN+1]};
      end else begin
         hiNext = sum[XLEN:1];
         loNext = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M multi-cycle mul/div sequencer. Operates on operand magnitudes and
// applies the result sign in a final correction cycle. Divide-by-zero and
// signed overflow bypass the iterations and answer one cycle after accept.
// Build option: define MULDIV_FAST_MUL_EN to run mul* ops through a
// combinational signed multiplier (2-cycle latency) instead of iterating.
module muldiv_ctrl import muldiv_ctrl_pkg::*; #(
   parameter int XLEN = MULDIV_XLEN
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   muldiv_ctrl_if.slave bus
);

   localparam int CW = $clog2(XLEN) + 1;

   muldiv_state_type state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;
   mul_op_type       mulOp_q, mulOp_d;
   div_op_type       divOp_q, divOp_d;
   logic             negRes_q, negRes_d;
   logic             negRem_q, negRem_d;
   logic             respValid_q, respValid_d;
   logic [XLEN-1:0]  respResult_q, respResult_d;

   logic            accept, reqIsMul, signA, signB, negA, negB, divZero, divOvf;
   logic [XLEN-1:0] absA, absB, minNeg;
   logic            isDivQ;
   logic [XLEN-1:0] stepHi, stepLo;
   logic [2*XLEN-1:0] prodFull, prodSigned;
   logic [XLEN-1:0] quoSigned, remSigned, corrResult;
   logic            useFast;
   logic [2*XLEN-1:0] fastProdU;

   // Request decode: operand signedness, magnitudes and the divide special cases.
   assign accept   = bus.req_valid & isOneHot8({bus.mul_op, bus.div_op});
   assign reqIsMul = (bus.mul_op != '0);
   assign signA    = bus.mul_op.mul | bus.mul_op.mulh | bus.mul_op.mulhsu |
                     bus.div_op.div | bus.div_op.rem;
   assign signB    = bus.mul_op.mul | bus.mul_op.mulh |
                     bus.div_op.div | bus.div_op.rem;
   assign negA     = signA & bus.rs1[XLEN-1];
   assign negB     = signB & bus.rs2[XLEN-1];
   assign absA     = negA ? -bus.rs1 : bus.rs1;
   assign absB     = negB ? -bus.rs2 : bus.rs2;
   assign minNeg   = {1'b1, {(XLEN-1){1'b0}}};
   assign divZero  = (bus.rs2 == '0);
   assign divOvf   = (bus.div_op.div | bus.div_op.rem) & (bus.rs1 == minNeg) & (&bus.rs2);

   assign isDivQ = (divOp_q != '0);

   muldiv_step #(.XLEN(XLEN)) step_u (
      .isDiv  (isDivQ),
      .hi     (hi_q),
      .lo     (lo_q),
      .opnd   (opnd_q),
      .hiNext (stepHi),
      .loNext (stepLo)
   );

   assign prodFull   = {hi_q, lo_q};
   assign prodSigned = negRes_q ? -prodFull : prodFull;
   assign quoSigned  = negRes_q ? -lo_q : lo_q;
   assign remSigned  = negRem_q ? -hi_q : hi_q;

`ifdef MULDIV_FAST_MUL_EN
   logic [XLEN:0]            fastA_q, fastA_d, fastB_q, fastB_d;
   logic signed [2*XLEN-1:0] fastAExt, fastBExt, fastProd;

   assign fastAExt  = {{(XLEN-1){fastA_q[XLEN]}}, fastA_q};
   assign fastBExt  = {{(XLEN-1){fastB_q[XLEN]}}, fastB_q};
   assign fastProd  = fastAExt * fastBExt;
   assign useFast   = (mulOp_q != '0);
   assign fastProdU = fastProd;
`else
   assign useFast   = 1'b0;
   assign fastProdU = '0;
`endif

   // Final result select: low or high product half, signed quotient or remainder.
   always_comb begin
      corrResult = remSigned;
      if (mulOp_q.mul) begin
         corrResult = prodSigned[XLEN-1:0];
      end else if (mulOp_q != '0) begin
         corrResult = prodSigned[2*XLEN-1:XLEN];
      end else if (divOp_q.div | divOp_q.divu) begin
         corrResult = quoSigned;
      end
   end

   // State register: everything returns to idle values on the active-low async reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         opnd_q       <= '0;
         mulOp_q      <= '0;
         divOp_q      <= '0;
         negRes_q     <= 1'b0;
         negRem_q     <= 1'b0;
         respValid_q  <= 1'b0;
         respResult_q <= '0;
`ifdef MULDIV_FAST_MUL_EN
         fastA_q      <= '0;
         fastB_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         opnd_q       <= opnd_d;
         mulOp_q      <= mulOp_d;
         divOp_q      <= divOp_d;
         negRes_q     <= negRes_d;
         negRem_q     <= negRem_d;
         respValid_q  <= respValid_d;
         respResult_q <= respResult_d;
`ifdef MULDIV_FAST_MUL_EN
         fastA_q      <= fastA_d;
         fastB_q      <= fastB_d;
`endif
      end
   end

   // Next-state logic: accept in IDLE, iterate in BUSY, sign-correct and respond in CORR; clear overrides all.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      opnd_d       = opnd_q;
      mulOp_d      = mulOp_q;
      divOp_d      = divOp_q;
      negRes_d     = negRes_q;
      negRem_d     = negRem_q;
      respValid_d  = 1'b0;
      respResult_d = respResult_q;
`ifdef MULDIV_FAST_MUL_EN
      fastA_d      = fastA_q;
      fastB_d      = fastB_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               mulOp_d = bus.mul_op;
               divOp_d = bus.div_op;
               cnt_d   = '0;
               hi_d    = '0;
               if (reqIsMul) begin
                  lo_d     = absB;
                  opnd_d   = absA;
                  negRes_d = negA ^ negB;
                  negRem_d = 1'b0;
                  state_d  = BUSY;
`ifdef MULDIV_FAST_MUL_EN
                  fastA_d  = {negA, bus.rs1};
                  fastB_d  = {negB, bus.rs2};
                  negRes_d = 1'b0;
`endif
               end else if (divZero) begin
                  lo_d     = '1;
                  hi_d     = bus.rs1;
                  negRes_d = 1'b0;
                  negRem_d = 1'b0;
                  state_d  = CORR;
               end else if (divOvf) begin
                  lo_d     = bus.rs1;
                  hi_d     = '0;
                  negRes_d = 1'b0;
                  negRem_d = 1'b0;
                  state_d  = CORR;
               end else begin
                  lo_d     = absA;
                  opnd_d   = absB;
                  negRes_d = negA ^ negB;
                  negRem_d = negA;
                  state_d  = BUSY;
               end
            end
         end
         BUSY: begin
            if (useFast) begin
               {hi_d, lo_d} = fastProdU;
               state_d      = CORR;
            end else begin
               hi_d  = stepHi;
               lo_d  = stepLo;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(XLEN-1)) begin
                  state_d = CORR;
               end
            end
         end
         CORR: begin
            respValid_d  = 1'b1;
            respResult_d = corrResult;
            cnt_d        = '0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (clear) begin
         state_d      = IDLE;
         cnt_d        = '0;
         respValid_d  = 1'b0;
         respResult_d = respResult_q;
      end
   end

   assign bus.req_ready   = (state_q == IDLE);
   assign bus.resp_valid  = respValid_q;
   assign bus.resp_result = respResult_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. Expected results come from plain
// 64-bit arithmetic on the RV32M rules; a per-cycle compare process checks
// resp_valid, resp_result and req_ready against that model.
module tb_muldiv_ctrl;
   import muldiv_ctrl_pkg::*;

   localparam int XLEN = 32;

   logic clock = 1'b0;
   logic reset;
   logic clear;

   muldiv_ctrl_if #(.XLEN(XLEN)) bus ();

   muldiv_ctrl #(.XLEN(XLEN)) dut (
      .clock (clock),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   int edgeCnt = 0;

   // Count rising edges so the model can predict the response cycle.
   always @(posedge clock) edgeCnt++;

   int          checks   = 0;
   int          failures = 0;
   bit          pendValid = 1'b0;
   int          pendDue   = 0;
   logic [31:0] pendResult = '0;
   logic [31:0] lastResult = '0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at edge %0d", name, actual, expected, edgeCnt);
      end
   endtask

   // Reference result: opIdx 0..7 = mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
   function automatic logic [31:0] refResult(input int opIdx, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ub;
      logic [63:0] p;
      int          ia, ib;
      bit          ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'b0, b});
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (opIdx)
         0: begin p = sa * sb; return p[31:0]; end
         1: begin p = sa * sb; return p[63:32]; end
         2: begin p = sa * ub; return p[63:32]; end
         3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            return 32'(ia / ib);
         end
         5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            return 32'(ia % ib);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   // Cycles from the accepting edge to the edge that raises resp_valid.
   function automatic int refLatency(input int opIdx, input logic [31:0] a, input logic [31:0] b);
      if (opIdx < 4) begin
`ifdef MULDIV_FAST_MUL_EN
         return 2;
`else
         return 33;
`endif
      end
      if (b == 0) return 1;
      if ((opIdx == 4 || opIdx == 6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Wait (bounded) until the model says the DUT is idle, then present one request for a cycle.
   task automatic applyRaw(input logic [3:0] mBits, input logic [3:0] dBits, input logic [31:0] a,
                           input logic [31:0] b, input bit withClear, input bit expectAccept,
                           input logic [31:0] expRes, input int lat);
      int guard;
      guard = 0;
      while (pendValid && guard < 100) begin
         @(negedge clock);
         #1;
         guard++;
      end
      if (pendValid) begin
         checks++;
         failures++;
         $display("[TB] FAIL idle_wait actual=busy expected=idle within 100 cycles");
         pendValid = 1'b0;
      end
      bus.req_valid = 1'b1;
      bus.mul_op    = mBits;
      bus.div_op    = dBits;
      bus.rs1       = a;
      bus.rs2       = b;
      clear         = withClear;
      if (expectAccept) begin
         pendValid  = 1'b1;
         pendDue    = edgeCnt + 1 + lat;
         pendResult = expRes;
      end
      @(negedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.mul_op    = '0;
      bus.div_op    = '0;
      clear         = 1'b0;
   endtask

   task automatic applyStimulus(input int opIdx, input logic [31:0] a, input logic [31:0] b);
      logic [3:0] m, d;
      m = 4'b1000;
      d = 4'b1000;
      if (opIdx < 4) begin
         m = m >> opIdx;
         d = 4'b0000;
      end else begin
         m = 4'b0000;
         d = d >> (opIdx - 4);
      end
      applyRaw(m, d, a, b, 1'b0, 1'b1, refResult(opIdx, a, b), refLatency(opIdx, a, b));
   endtask

   // Per-cycle compare against the model, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clock);
         if (pendValid && edgeCnt == pendDue) begin
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("resp_result", bus.resp_result, pendResult);
            checkOutput("req_ready", 32'(bus.req_ready), 32'd1);
            lastResult = pendResult;
            pendValid  = 1'b0;
         end else begin
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'd0);
            checkOutput("resp_result", bus.resp_result, lastResult);
            checkOutput("req_ready", 32'(bus.req_ready), pendValid ? 32'd0 : 32'd1);
         end
      end
   end

   int          dirOp [14] = '{0, 1, 3, 2, 4, 6, 5, 7, 4, 6, 4, 6, 5, 7};
   logic [31:0] dirA  [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'd7, 32'd7, 32'd5, 32'd5, 32'h8000_0000,
                               32'h8000_0000, 32'd5, 32'd5};
   logic [31:0] dirB  [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                               32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd0, 32'd0};

   initial begin
      int guard;
      reset         = 1'b0;
      clear         = 1'b0;
      bus.req_valid = 1'b0;
      bus.mul_op    = '0;
      bus.div_op    = '0;
      bus.rs1       = '0;
      bus.rs2       = '0;
      repeat (2) @(negedge clock);
      #1;
      reset = 1'b1;

      // Hand-computed values that pin the reference model.
      checkOutput("pin_mul", refResult(0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
      checkOutput("pin_mulh", refResult(1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
      checkOutput("pin_mulhu", refResult(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
      checkOutput("pin_mulhsu", refResult(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
      checkOutput("pin_div", refResult(4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
      checkOutput("pin_rem", refResult(6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
      checkOutput("pin_rem_div0", refResult(6, 32'd5, 32'd0), 32'd5);
      checkOutput("pin_div_ovf", refResult(4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      checkOutput("pin_lat_div0", 32'(refLatency(4, 32'd5, 32'd0)), 32'd1);
      checkOutput("pin_lat_divu", 32'(refLatency(5, 32'd7, 32'd2)), 32'd33);

      // Directed vectors, issued back-to-back.
      for (int i = 0; i < 14; i++) begin
         applyStimulus(dirOp[i], dirA[i], dirB[i]);
      end

      // Illegal op encodings and a request colliding with clear are all ignored.
      applyRaw(4'b0000, 4'b0000, 32'd9, 32'd9, 1'b0, 1'b0, '0, 0);
      applyRaw(4'b1000, 4'b0100, 32'd9, 32'd9, 1'b0, 1'b0, '0, 0);
      applyRaw(4'b1000, 4'b0000, 32'd9, 32'd9, 1'b1, 1'b0, '0, 0);

      // Clear about ten cycles into a divu, then a fresh mul.
      applyStimulus(5, 32'h1234_5678, 32'd3);
      repeat (9) @(negedge clock);
      #1;
      clear     = 1'b1;
      pendValid = 1'b0;
      @(negedge clock);
      #1;
      clear = 1'b0;
      applyStimulus(0, 32'd3, 32'd4);

      // Reset in the middle of a divide.
      applyStimulus(4, 32'd1000, 32'd7);
      repeat (5) @(negedge clock);
      #1;
      reset      = 1'b0;
      pendValid  = 1'b0;
      lastResult = '0;
      @(negedge clock);
      #1;
      reset = 1'b1;

      // Randomized ops with occasional idle gaps.
      for (int i = 0; i < 60; i++) begin
         int          op;
         logic [31:0] a, b;
         op = $urandom_range(0, 7);
         a  = pickOperand();
         b  = pickOperand();
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clock);
            #1;
         end
         applyStimulus(op, a, b);
      end

      guard = 0;
      while (pendValid && guard < 100) begin
         @(negedge clock);
         #1;
         guard++;
      end
      if (pendValid) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain actual=busy expected=idle within 100 cycles");
      end
      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
